bit_serial_adder: RTL and testbench

//   Multi-bit adder built on a single full-adder cell. The cell is reused once per clock, LSB first.

---
 rtl/bit_serial_pkg.sv | 12 +
 rtl/fa_cell.sv | 13 +
 rtl/bit_serial_adder.sv | 127 ++++++++++++
 tb/tb_bit_serial_adder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package bit_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// Single combinational full-adder cell, reused once per clock by the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell iterated LSB first, WIDTH cycles per add.
// Optional macro BIT_SERIAL_ADD_OVF_EN adds a two's-complement overflow output (ovf).
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef BIT_SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             fa_s, fa_c;
`ifdef BIT_SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  fa_cell u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .cin   (c_q),
    .sum   (fa_s),
    .carry (fa_c)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
`ifdef BIT_SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        c_d      = fa_c;
        cnt_d    = cnt_q + CW'(1);
        // Last bit: commit includes the bit computed this cycle, so outputs never show partials.
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = sum_sh_d;
          carry_d = fa_c;
`ifdef BIT_SERIAL_ADD_OVF_EN
          ovf_d   = c_q ^ fa_c;
`endif
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
`ifdef BIT_SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
`ifdef BIT_SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign carry = carry_q;
`ifdef BIT_SERIAL_ADD_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, carry;
  logic [W-1:0] sum;
`ifdef BIT_SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  logic fa_a, fa_b, fa_ci, fa_s, fa_co;

  int n_vec = 0;
  int n_bad = 0;

  logic [W-1:0] exp_sum   = '0;
  logic         exp_carry = 1'b0;
  logic         exp_ovf   = 1'b0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
`ifdef BIT_SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  fa_cell u_fa_ref (
    .a     (fa_a),
    .b     (fa_b),
    .cin   (fa_ci),
    .sum   (fa_s),
    .carry (fa_co)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".sum"}, 64'(sum), 64'(exp_sum));
    chk({tag, ".carry"}, 64'(carry), 64'(exp_carry));
`ifdef BIT_SERIAL_ADD_OVF_EN
    chk({tag, ".ovf"}, 64'(ovf), 64'(exp_ovf));
`endif
  endtask

  // One full add; 'noise' pulses start with junk operands mid-RUN and in DONE.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input bit noise);
    logic [W:0] total;
    int         sa, sb, ss;
    total = (W+1)'(ta) + (W+1)'(tb_v) + (W+1)'(tc);
    sa = ta[W-1] ? int'(ta) - (1 << W) : int'(ta);
    sb = tb_v[W-1] ? int'(tb_v) - (1 << W) : int'(tb_v);
    ss = sa + sb + int'(tc);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      chk($sformatf("busy.k%0d", k), 64'(busy), 64'(1));
      chk($sformatf("done.k%0d", k), 64'(done), 64'(k == W + 1));
      if (k == W + 1) begin
        exp_sum   = total[W-1:0];
        exp_carry = total[W];
        exp_ovf   = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
      end
      if (k == 1 || k == W || k == W + 1) chk_outputs($sformatf("res.k%0d", k));
      if (noise && (k == 3 || k == W + 1)) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("idle.busy", 64'(busy), 64'(0));
    chk("idle.done", 64'(done), 64'(0));
    chk_outputs("idle");
    $display("op a=%02h b=%02h cin=%0d noise=%0d -> sum=%02h carry=%0d", ta, tb_v, tc, noise, sum, carry);
  endtask

  initial begin
    // fa_cell exhaustive
    for (int i = 0; i < 8; i++) begin
      {fa_a, fa_b, fa_ci} = 3'(i);
      #1;
      chk($sformatf("fa_cell.%0d", i), 64'({fa_co, fa_s}), 64'(2'(fa_a) + 2'(fa_b) + 2'(fa_ci)));
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(done), 64'(0));
    chk_outputs("rst");
    rst_n = 1'b1;

    // Directed cases
    run_op(8'h35, 8'h4A, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op(8'h10, 8'h20, 1'b0, 1'b1);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 1'b0);

    // Reset in RUN cycle 4
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_sum = '0; exp_carry = 1'b0; exp_ovf = 1'b0;
    chk("abort.busy", 64'(busy), 64'(0));
    chk("abort.done", 64'(done), 64'(0));
    chk_outputs("abort");
    $display("reset asserted mid-RUN: busy=%0d sum=%02h", busy, sum);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h01, 8'h01, 1'b0, 1'b0);

    // Randomized operands, some with ignored start pulses
    for (int r = 0; r < 24; r++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
